// File: rtl/multicycle_controller.sv
// Moore control FSM for the 16-bit multicycle datapath: sequences fetch, decode and
// the per-class execute/writeback cycles, emitting datapath strobes and selects.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        DM,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        ARS,
  output logic        RegWrite,
  output logic        IMS,
  output logic        NI,
  output logic [2:0]  ALUop,
  output logic [1:0]  PCSrc,
  output logic [1:0]  MemToReg
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StLdMem, StLdWb, StStMem, StJmp, StBrz,
    StCExec, StCWb, StIExec, StIWb
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] opcode_q;
  logic [2:0] func_q;
  logic [3:0] opcode;
  logic [2:0] c_alu_op;
  logic       unused_fields;

  assign opcode        = instruction[15:12];
  assign unused_fields = ^instruction[11:3];

  // Opcode/func are latched while leaving DECODE so later outputs depend on registers only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StFetch;
      opcode_q <= '0;
      func_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        opcode_q <= opcode;
        func_q   <= instruction[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        unique casez (opcode)
          4'b0000: state_d = StLdMem;
          4'b0001: state_d = StStMem;
          4'b0010: state_d = StJmp;
          4'b0100: state_d = StBrz;
          4'b1000: state_d = StCExec;
          4'b11??: state_d = StIExec;
          default: state_d = StFetch;
        endcase
      end
      StLdMem: state_d = StLdWb;
      StCExec: state_d = StCWb;
      StIExec: state_d = StIWb;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    c_alu_op = 3'b000;
    unique case (func_q)
      3'b001:  c_alu_op = 3'b101;
      3'b010:  c_alu_op = 3'b000;
      3'b011:  c_alu_op = 3'b001;
      3'b100:  c_alu_op = 3'b010;
      3'b101:  c_alu_op = 3'b011;
      3'b110:  c_alu_op = 3'b100;
      default: c_alu_op = 3'b000;
    endcase
  end

  // Outputs are forced low combinationally while reset is asserted.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    DM          = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ARS         = 1'b0;
    RegWrite    = 1'b0;
    IMS         = 1'b0;
    NI          = 1'b0;
    ALUop       = 3'b000;
    PCSrc       = 2'b00;
    MemToReg    = 2'b00;
    if (rst) begin
      unique case (state_q)
        StFetch: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          NI      = 1'b1;
          PCWrite = 1'b1;
        end
        StDecode: ARS = 1'b1;
        StLdMem: begin
          DM      = 1'b1;
          MemRead = 1'b1;
        end
        StLdWb: begin
          ARS      = 1'b1;
          MemToReg = 2'b01;
          RegWrite = 1'b1;
        end
        StStMem: begin
          DM       = 1'b1;
          MemWrite = 1'b1;
          ARS      = 1'b1;
        end
        StJmp: begin
          PCSrc   = 2'b01;
          PCWrite = 1'b1;
        end
        StBrz: begin
          ARS         = 1'b1;
          ALUop       = 3'b001;
          PCSrc       = 2'b10;
          PCWriteCond = 1'b1;
        end
        StCExec: begin
          ARS   = 1'b1;
          ALUop = c_alu_op;
        end
        StCWb: begin
          ALUop = c_alu_op;
          unique case (func_q)
            3'b000: RegWrite = 1'b1;
            3'b111: RegWrite = 1'b0;
            default: begin
              ARS      = 1'b1;
              MemToReg = 2'b10;
              RegWrite = 1'b1;
            end
          endcase
        end
        StIExec: begin
          ARS   = 1'b1;
          IMS   = 1'b1;
          ALUop = {1'b0, opcode_q[1:0]};
        end
        StIWb: begin
          ARS      = 1'b1;
          IMS      = 1'b1;
          ALUop    = {1'b0, opcode_q[1:0]};
          MemToReg = 2'b10;
          RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected output
// sequences from a behavioural model, plus literal pins and reset checks.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       dm;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       ars;
    logic       reg_write;
    logic       ims;
    logic       ni;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
  } ctl_t;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic        PCWrite, PCWriteCond, IorD, DM, MemRead, MemWrite, IRWrite;
  logic        ARS, RegWrite, IMS, NI;
  logic [2:0]  ALUop;
  logic [1:0]  PCSrc, MemToReg;

  ctl_t        dut_v;
  ctl_t        exp_q[$];
  logic [15:0] cur_ins;
  int          checks = 0;
  int          fails = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .DM(DM),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .ARS(ARS),
    .RegWrite(RegWrite), .IMS(IMS), .NI(NI), .ALUop(ALUop), .PCSrc(PCSrc),
    .MemToReg(MemToReg)
  );

  assign dut_v = {PCWrite, PCWriteCond, IorD, DM, MemRead, MemWrite, IRWrite,
                  ARS, RegWrite, IMS, NI, ALUop, PCSrc, MemToReg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check_ctl(input string nm, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s ins=%h: got %b required %b", nm, cur_ins, act, exp);
    end
  endfunction

  function automatic void check_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s ins=%h: got %b required %b", nm, cur_ins, act, exp);
    end
  endfunction

  // Expected per-cycle outputs for one instruction, from its class and fields.
  function automatic void model(input logic [15:0] ins);
    ctl_t       c;
    logic [2:0] alu;
    logic [2:0] fn;
    fn = ins[2:0];
    c = '0; c.pc_write = 1; c.mem_read = 1; c.ir_write = 1; c.ni = 1;
    exp_q.push_back(c);
    c = '0; c.ars = 1;
    exp_q.push_back(c);
    if (ins[15:12] == 4'h0) begin
      c = '0; c.dm = 1; c.mem_read = 1; exp_q.push_back(c);
      c = '0; c.ars = 1; c.mem_to_reg = 2'b01; c.reg_write = 1; exp_q.push_back(c);
    end else if (ins[15:12] == 4'h1) begin
      c = '0; c.dm = 1; c.mem_write = 1; c.ars = 1; exp_q.push_back(c);
    end else if (ins[15:12] == 4'h2) begin
      c = '0; c.pc_src = 2'b01; c.pc_write = 1; exp_q.push_back(c);
    end else if (ins[15:12] == 4'h4) begin
      c = '0; c.ars = 1; c.alu_op = 3'b001; c.pc_src = 2'b10; c.pc_write_cond = 1;
      exp_q.push_back(c);
    end else if (ins[15:12] == 4'h8) begin
      case (fn)
        3'd1:    alu = 3'b101;
        3'd2:    alu = 3'b000;
        3'd3:    alu = 3'b001;
        3'd4:    alu = 3'b010;
        3'd5:    alu = 3'b011;
        3'd6:    alu = 3'b100;
        default: alu = 3'b000;
      endcase
      c = '0; c.ars = 1; c.alu_op = alu; exp_q.push_back(c);
      c = '0; c.alu_op = alu;
      if (fn == 3'd0) c.reg_write = 1;
      else if (fn != 3'd7) begin c.ars = 1; c.mem_to_reg = 2'b10; c.reg_write = 1; end
      exp_q.push_back(c);
    end else if (ins[15:14] == 2'b11) begin
      c = '0; c.ars = 1; c.ims = 1; c.alu_op = {1'b0, ins[13:12]}; exp_q.push_back(c);
      c.mem_to_reg = 2'b10; c.reg_write = 1; exp_q.push_back(c);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (exp_q.size() > 0) check_ctl("model", dut_v, exp_q.pop_front());
      check_bit("pcwrite_excl", PCWrite & PCWriteCond, 1'b0);
      check_bit("mem_excl", MemRead & MemWrite, 1'b0);
    end
  end

  // Called aligned just after a rising edge with the FSM in FETCH; returns likewise.
  task automatic run_model(input logic [15:0] ins);
    int guard = 0;
    cur_ins = ins;
    instruction = ~ins;  // garbage during FETCH must not matter
    model(ins);
    @(negedge clk);
    #1 instruction = ins;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout ins=%h: %0d cycles left", ins, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pin(input string nm, input logic [15:0] ins, input ctl_t v[4], input int n);
    cur_ins = ins;
    instruction = ~ins;
    @(negedge clk);
    check_ctl(nm, dut_v, v[0]);
    #1 instruction = ins;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      check_ctl(nm, dut_v, v[i]);
    end
    @(posedge clk);
    #1;
  endtask

  localparam ctl_t VFetch  = 18'b1000101_0001_000_00_00;
  localparam ctl_t VDecode = 18'b0000000_1000_000_00_00;

  ctl_t        pv[4];
  logic [15:0] prog[16];

  initial begin
    cur_ins = 16'h0;
    rst = 1'b0;
    instruction = 16'h0;
    #2 check_ctl("reset_zero", dut_v, '0);
    repeat (2) @(posedge clk);
    #1 check_ctl("reset_hold", dut_v, '0);
    rst = 1'b1;
    #1 check_ctl("release_fetch", dut_v, VFetch);

    pv[0] = VFetch; pv[1] = VDecode;
    pv[2] = 18'b0001100_0000_000_00_00; pv[3] = 18'b0000000_1100_000_00_01;
    pin("pin_load", 16'h0123, pv, 4);
    pv[2] = 18'b0100000_1000_001_10_00;
    pin("pin_brz", 16'h4205, pv, 3);
    pin("pin_illegal", 16'h3000, pv, 2);
    pv[2] = 18'b0000000_1000_000_00_00; pv[3] = 18'b0000000_0100_000_00_00;
    pin("pin_moveto", 16'h8600, pv, 4);
    pv[3] = 18'b0000000_0000_000_00_00;
    pin("pin_nop", 16'h8607, pv, 4);
    pv[2] = 18'b0000000_1010_001_00_00; pv[3] = 18'b0000000_1110_001_00_10;
    pin("pin_subi", 16'hD0FF, pv, 4);

    prog = '{16'h0123, 16'h1ABC, 16'h2456, 16'h4205, 16'h8601, 16'h8602, 16'h8603,
             16'h8604, 16'h8605, 16'h8606, 16'hC123, 16'hE00F, 16'hF7F0, 16'h3000,
             16'h5FFF, 16'h9000};
    foreach (prog[i]) run_model(prog[i]);
    run_model(16'hA000);
    run_model(16'h7123);

    // Asynchronous reset while in LD_WB.
    cur_ins = 16'h0123;
    instruction = 16'h0123;
    repeat (3) @(posedge clk);
    #1 check_bit("ldwb_regwrite", RegWrite, 1'b1);
    rst = 1'b0;
    #1 check_bit("async_regwrite", RegWrite, 1'b0);
    check_ctl("async_zero", dut_v, '0);
    @(posedge clk);
    #1 check_ctl("async_hold", dut_v, '0);
    rst = 1'b1;
    #1 check_ctl("async_release", dut_v, VFetch);
    run_model(16'h0123);
    run_model(16'h2FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 instruction  in  16  IR contents; opcode = [15:12], Ri = [11:9], func = [2:0], address/immediate = [11:0].
REQ-005 PCWrite, PCWriteCond, IorD, DM, MemRead, MemWrite, IRWrite, ARS, RegWrite, IMS, NI  out  1 each  datapath strobes/selects.
REQ-006 ALUop  out  3  000 top+bottom, 001 top-bottom, 010 AND, 011 OR, 100 NOT top, 101 pass top.
REQ-007 PCSrc  out  2  00 ALU result, 01 IR[11:0], 10 {PC[11:9],IR[8:0]}.
REQ-008 MemToReg  out  2  00 B, 01 MDR, 10 ALUout.

Function
REQ-009 Moore FSM; outputs SHALL be decoded from state plus registered-state instruction fields only; any output not listed for a state SHALL be 0.
REQ-010 States: FETCH, DECODE, LD_MEM, LD_WB, ST_MEM, JMP, BRZ, C_EXEC, C_WB, I_EXEC, I_WB.
REQ-011 FETCH: MemRead=1, IRWrite=1, NI=1, ALUop=000, PCSrc=00, PCWrite=1, IorD=0, DM=0; next DECODE.
REQ-012 DECODE: ARS=1; next by opcode: 0000 LD_MEM, 0001 ST_MEM, 0010 JMP, 0100 BRZ, 1000 C_EXEC, 11xx I_EXEC, any other FETCH (illegal opcode, no side effects).
REQ-013 LD_MEM: DM=1, MemRead=1; next LD_WB. LD_WB: ARS=1, MemToReg=01, RegWrite=1; next FETCH (R0 <- M[IR[11:0]]).
REQ-014 ST_MEM: DM=1, MemWrite=1, ARS=1; next FETCH (M[IR[11:0]] <- R0).
REQ-015 JMP: PCSrc=01, PCWrite=1; next FETCH.
REQ-016 BRZ: ARS=1, IMS=0, NI=0, ALUop=001, PCSrc=10, PCWriteCond=1; next FETCH (if Ri==R0, PC <- {PC[11:9],IR[8:0]} using already-incremented PC).
REQ-017 C_EXEC: ARS=1, IMS=0, NI=0, ALUop by func: 001 pass(101), 010 ADD(000), 011 SUB(001, Ri-R0), 100 AND(010), 101 OR(011), 110 NOT(100), 000/111 -> 000; next C_WB.
REQ-018 C_WB: ALUop/IMS/NI held as C_EXEC; func 000 (MOVETO Ri <- R0): ARS=0, MemToReg=00, RegWrite=1; func 111 (NOP): RegWrite=0; else ARS=1, MemToReg=10, RegWrite=1; next FETCH.
REQ-019 I_EXEC: ARS=1, IMS=1, NI=0, ALUop by opcode[1:0]: 00->000 (ADDI), 01->001 (SUBI, SE(imm)-R0), 10->010 (ANDI), 11->011 (ORI); next I_WB.
REQ-020 I_WB: I_EXEC selects held, ARS=1, MemToReg=10, RegWrite=1; next FETCH.
REQ-021 Latency in cycles: LOAD 4, STORE 3, JUMP 3, BRZ 3, C-type 4, I-type 4, illegal 2.
REQ-022 PCWrite and PCWriteCond SHALL never be 1 in the same cycle; MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-023 instruction SHALL be sampled only in DECODE and later states; its value during FETCH SHALL NOT affect outputs.

Reset
REQ-024 rst low SHALL immediately, without a clock edge, force state=FETCH and every output to 0, including mid-instruction.
REQ-025 The first rising clk edge after rst goes high SHALL complete a FETCH cycle with FETCH outputs.

Verification
REQ-026 Reset released, instruction=16'h0123 -> cycle 1 FETCH strobes; cycle 2 ARS=1 only; cycle 3 DM=1, MemRead=1; cycle 4 MemToReg=01, RegWrite=1, ARS=1; cycle 5 FETCH.
REQ-027 instruction=16'h4205 -> BRZ cycle PCWriteCond=1, PCSrc=10, ALUop=001, PCWrite=0; return to FETCH after 3 cycles.
REQ-028 instruction=16'h8600 (MOVETO R3) -> C_EXEC ARS=1; C_WB ARS=0, MemToReg=00, RegWrite=1; instruction=16'h8607 -> C_WB RegWrite=0.
REQ-029 instruction=16'hD0FF (SUBI) -> I_EXEC IMS=1, ALUop=001; I_WB MemToReg=10, RegWrite=1.
REQ-030 instruction=16'h3000 (illegal) -> FETCH, DECODE, FETCH; MemWrite, RegWrite, PCWrite stay 0 in DECODE.
REQ-031 rst pulsed low during LD_WB -> RegWrite drops to 0 before next clk edge; FETCH resumes after release.
